// File: rtl/unsigned_mul_8x8_ha_array_seq_if.sv
// Operand/result handshake bus of the 8x8 half-adder-array multiplier.
// The bus also carries the operand drive to the ha_array stage and the row vectors that come back from it.
interface unsigned_mul_8x8_ha_array_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_x;
  logic [7:0] in_y;
  logic [3:0] cfg_row_mask;
  logic [7:0] mul_x;
  logic [7:0] mul_y;
  logic [6:0] ha_array_0_b;
  logic [6:0] ha_array_1_b;
  logic [6:0] ha_array_2_b;
  logic [6:0] ha_array_3_b;
  logic [8:0] ha_array_0_t;
  logic [8:0] ha_array_1_t;
  logic [8:0] ha_array_2_t;
  logic [8:0] ha_array_3_t;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic        out_sat;
  logic        busy;

  modport master (
    output in_valid, in_x, in_y, cfg_row_mask, out_ready,
    output ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
    output ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
    input  in_ready, mul_x, mul_y, out_valid, out_p, out_sat, busy
  );

  modport slave (
    input  in_valid, in_x, in_y, cfg_row_mask, out_ready,
    input  ha_array_0_b, ha_array_1_b, ha_array_2_b, ha_array_3_b,
    input  ha_array_0_t, ha_array_1_t, ha_array_2_t, ha_array_3_t,
    output in_ready, mul_x, mul_y, out_valid, out_p, out_sat, busy
  );
endinterface

// File: rtl/unsigned_mul_8x8_ha_array_seq.sv
// Sequential accumulator for the half-adder-array multiplier: one row pair per cycle, four cycles per product.
// Zero operands skip accumulation entirely; the result saturates or wraps at 16 bits depending on SAT_EN.
module unsigned_mul_8x8_ha_array_seq #(
  parameter bit SAT_EN = 1'b1
) (
  input logic clk,
  input logic rst_n,
  unsigned_mul_8x8_ha_array_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [17:0] acc_q;
  logic [1:0]  row_q;
  logic [7:0]  x_q;
  logic [7:0]  y_q;
  logic [3:0]  mask_q;

  logic [8:0]  row_t;
  logic [6:0]  row_b;
  logic [9:0]  row_val;
  logic [17:0] row_term;
  logic        zero_op;
  logic        sat_flag;

  // Row pair k contributes (t + 4*b) weighted by 4^k.
  always_comb begin
    row_t = '0;
    row_b = '0;
    case (row_q)
      2'd0: begin row_t = bus.ha_array_0_t; row_b = bus.ha_array_0_b; end
      2'd1: begin row_t = bus.ha_array_1_t; row_b = bus.ha_array_1_b; end
      2'd2: begin row_t = bus.ha_array_2_t; row_b = bus.ha_array_2_b; end
      default: begin row_t = bus.ha_array_3_t; row_b = bus.ha_array_3_b; end
    endcase
    row_val  = {1'b0, row_t} + {1'b0, row_b, 2'b00};
    row_term = {8'd0, row_val} << {row_q, 1'b0};
    zero_op  = (x_q == 8'd0) || (y_q == 8'd0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = ACC;
      ACC:  if (zero_op || row_q == 2'd3) state_d = DONE;
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      row_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            x_q    <= bus.in_x;
            y_q    <= bus.in_y;
            mask_q <= bus.cfg_row_mask;
            acc_q  <= '0;
            row_q  <= '0;
          end
        end
        ACC: begin
          if (!zero_op) begin
            if (mask_q[row_q]) acc_q <= acc_q + row_term;
            row_q <= row_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // The worst-case sum stays below 2^17, so bit 17 of the accumulator never sets.
  assign sat_flag      = acc_q > 18'h0FFFF;
  assign bus.out_sat   = sat_flag;
  assign bus.out_p     = (SAT_EN && sat_flag) ? 16'hFFFF : acc_q[15:0];
  assign bus.out_valid = (state_q == DONE);
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.mul_x     = x_q;
  assign bus.mul_y     = y_q;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_seq.sv
// Randomized bench for the sequential ha_array multiplier, run against a saturating and a wrapping instance.
// Expected products come from a plain-arithmetic model of the weighted row sum.
module tb_unsigned_mul_8x8_ha_array_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unsigned_mul_8x8_ha_array_seq_if if_s ();
  unsigned_mul_8x8_ha_array_seq_if if_w ();

  logic [8:0] t_v [4];
  logic [6:0] b_v [4];

  int checks = 0;
  int errors = 0;

  unsigned_mul_8x8_ha_array_seq #(.SAT_EN(1'b1)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(if_s));
  unsigned_mul_8x8_ha_array_seq #(.SAT_EN(1'b0)) dut_wrap (.clk(clk), .rst_n(rst_n), .bus(if_w));

  assign if_s.ha_array_0_t = t_v[0];
  assign if_s.ha_array_1_t = t_v[1];
  assign if_s.ha_array_2_t = t_v[2];
  assign if_s.ha_array_3_t = t_v[3];
  assign if_s.ha_array_0_b = b_v[0];
  assign if_s.ha_array_1_b = b_v[1];
  assign if_s.ha_array_2_b = b_v[2];
  assign if_s.ha_array_3_b = b_v[3];
  assign if_w.ha_array_0_t = t_v[0];
  assign if_w.ha_array_1_t = t_v[1];
  assign if_w.ha_array_2_t = t_v[2];
  assign if_w.ha_array_3_t = t_v[3];
  assign if_w.ha_array_0_b = b_v[0];
  assign if_w.ha_array_1_b = b_v[1];
  assign if_w.ha_array_2_b = b_v[2];
  assign if_w.ha_array_3_b = b_v[3];
  assign if_w.in_valid     = if_s.in_valid;
  assign if_w.in_x         = if_s.in_x;
  assign if_w.in_y         = if_s.in_y;
  assign if_w.cfg_row_mask = if_s.cfg_row_mask;
  assign if_w.out_ready    = if_s.out_ready;

  // Result = sum over enabled rows of (t_i + 4*b_i) * 4^i, zero if either operand is zero.
  function automatic logic [16:0] model(input logic [7:0] x, input logic [7:0] y,
                                        input logic [3:0] m, input bit sat_en);
    int acc;
    acc = 0;
    if (x != 8'd0 && y != 8'd0)
      for (int i = 0; i < 4; i++)
        if (m[i]) acc += (int'(t_v[i]) + 4 * int'(b_v[i])) * (1 << (2 * i));
    if (acc > 65535) return {1'b1, (sat_en ? 16'hFFFF : acc[15:0])};
    return {1'b0, acc[15:0]};
  endfunction

  task automatic set_rows_random();
    for (int i = 0; i < 4; i++) begin
      t_v[i] = 9'($urandom);
      b_v[i] = 7'($urandom);
    end
  endtask

  task automatic set_rows(input logic [8:0] t, input logic [6:0] b);
    for (int i = 0; i < 4; i++) begin
      t_v[i] = t;
      b_v[i] = b;
    end
  endtask

  // Issue one request, wait for the result, then retire it; lat is 0 when no result appears.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic [3:0] m,
                               output int lat, output logic [15:0] ps, output logic ss,
                               output logic [15:0] pw, output logic sw, output logic [7:0] mx);
    @(negedge clk);
    if_s.in_valid = 1'b1;
    if_s.in_x = x;
    if_s.in_y = y;
    if_s.cfg_row_mask = m;
    @(posedge clk);
    #1;
    if_s.in_valid = 1'b0;
    mx = if_s.mul_x;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (if_s.out_valid) lat = n + 1;
    end
    ps = if_s.out_p;
    ss = if_s.out_sat;
    pw = if_w.out_p;
    sw = if_w.out_sat;
    @(negedge clk);
    if_s.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if_s.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (if_s.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", if_s.busy); end
    checks++; if (if_s.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got %b want 0", if_s.out_valid); end
    checks++; if (if_s.out_p !== 16'h0 || if_s.out_sat !== 1'b0) begin errors++; $display("[TB] FAIL reset_out got %h/%b want 0000/0", if_s.out_p, if_s.out_sat); end
    checks++; if (if_s.mul_x !== 8'h0 || if_s.mul_y !== 8'h0) begin errors++; $display("[TB] FAIL reset_mul got %h/%h want 00/00", if_s.mul_x, if_s.mul_y); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (if_s.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", if_s.in_ready); end
  endtask

  task automatic test_directed();
    int lat;
    logic [15:0] ps, pw;
    logic ss, sw;
    logic [7:0] mx;
    set_rows(9'h001, 7'h00);
    applyStimulus(8'd3, 8'd5, 4'hF, lat, ps, ss, pw, sw, mx);
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL unit_rows_latency got %0d want 5", lat); end
    checks++; if (ps !== 16'd85 || ss !== 1'b0) begin errors++; $display("[TB] FAIL unit_rows_p got %0d/%b want 85/0", ps, ss); end
    checks++; if (mx !== 8'd3) begin errors++; $display("[TB] FAIL unit_rows_mul_x got %h want 03", mx); end

    set_rows(9'h1FF, 7'h7F);
    applyStimulus(8'd200, 8'd77, 4'hF, lat, ps, ss, pw, sw, mx);
    checks++; if (ps !== 16'hFFFF || ss !== 1'b1) begin errors++; $display("[TB] FAIL sat_clamp got %h/%b want ffff/1", ps, ss); end
    checks++; if (pw !== 16'h5257 || sw !== 1'b1) begin errors++; $display("[TB] FAIL sat_wrap got %h/%b want 5257/1", pw, sw); end

    set_rows_random();
    applyStimulus(8'd0, 8'hAB, 4'hF, lat, ps, ss, pw, sw, mx);
    checks++; if (lat !== 2) begin errors++; $display("[TB] FAIL zero_fast_latency got %0d want 2", lat); end
    checks++; if (ps !== 16'h0 || ss !== 1'b0 || pw !== 16'h0) begin errors++; $display("[TB] FAIL zero_fast_p got %h/%b/%h want 0000/0/0000", ps, ss, pw); end

    set_rows(9'h155, 7'h2A);
    t_v[2] = 9'h003;
    b_v[2] = 7'h001;
    applyStimulus(8'd9, 8'd11, 4'b0100, lat, ps, ss, pw, sw, mx);
    checks++; if (ps !== 16'd112 || ss !== 1'b0) begin errors++; $display("[TB] FAIL single_row got %0d/%b want 112/0", ps, ss); end

    set_rows_random();
    applyStimulus(8'd9, 8'd11, 4'b0000, lat, ps, ss, pw, sw, mx);
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL mask_zero_latency got %0d want 5", lat); end
    checks++; if (ps !== 16'h0 || ss !== 1'b0) begin errors++; $display("[TB] FAIL mask_zero_p got %h/%b want 0000/0", ps, ss); end
  endtask

  task automatic test_random();
    int lat, exp_lat;
    logic [15:0] ps, pw;
    logic ss, sw;
    logic [7:0] mx, x, y;
    logic [3:0] m;
    logic [16:0] es, ew;
    for (int it = 0; it < 40; it++) begin
      set_rows_random();
      x = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      y = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      m = 4'($urandom);
      es = model(x, y, m, 1'b1);
      ew = model(x, y, m, 1'b0);
      exp_lat = (x == 8'd0 || y == 8'd0) ? 2 : 5;
      applyStimulus(x, y, m, lat, ps, ss, pw, sw, mx);
      checks++; if (lat !== exp_lat) begin errors++; $display("[TB] FAIL rand_latency it=%0d got %0d want %0d", it, lat, exp_lat); end
      checks++; if ({ss, ps} !== es) begin errors++; $display("[TB] FAIL rand_sat it=%0d got %b/%h want %b/%h", it, ss, ps, es[16], es[15:0]); end
      checks++; if ({sw, pw} !== ew) begin errors++; $display("[TB] FAIL rand_wrap it=%0d got %b/%h want %b/%h", it, sw, pw, ew[16], ew[15:0]); end
      checks++; if (mx !== x) begin errors++; $display("[TB] FAIL rand_mul_x it=%0d got %h want %h", it, mx, x); end
    end
  endtask

  task automatic test_hold();
    logic [7:0] x, y;
    logic [16:0] es;
    bit seen;
    set_rows_random();
    x = 8'($urandom_range(1, 255));
    y = 8'($urandom_range(1, 255));
    es = model(x, y, 4'hF, 1'b1);
    @(negedge clk);
    if_s.in_valid = 1'b1; if_s.in_x = x; if_s.in_y = y; if_s.cfg_row_mask = 4'hF;
    @(posedge clk);
    #1;
    if_s.in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(posedge clk);
      #1;
      seen = if_s.out_valid;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL hold_done got no out_valid want out_valid"); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if_s.in_valid = i[0];
      if_s.in_x = 8'($urandom);
      if_s.in_y = 8'($urandom);
      if_s.cfg_row_mask = 4'($urandom);
      @(posedge clk);
      #1;
      checks++; if (if_s.out_p !== es[15:0] || if_s.out_sat !== es[16]) begin errors++; $display("[TB] FAIL hold_p cyc=%0d got %h/%b want %h/%b", i, if_s.out_p, if_s.out_sat, es[15:0], es[16]); end
      checks++; if (if_s.in_ready !== 1'b0 || if_s.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_hs cyc=%0d got rdy=%b vld=%b want 0/1", i, if_s.in_ready, if_s.out_valid); end
      checks++; if (if_s.mul_x !== x || if_s.mul_y !== y) begin errors++; $display("[TB] FAIL hold_mul cyc=%0d got %h/%h want %h/%h", i, if_s.mul_x, if_s.mul_y, x, y); end
    end
    @(negedge clk);
    if_s.in_valid = 1'b0;
    if_s.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if_s.out_ready = 1'b0;
    checks++; if (if_s.out_valid !== 1'b0 || if_s.busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_release got vld=%b busy=%b want 0/0", if_s.out_valid, if_s.busy); end
    @(posedge clk);
    #1;
    checks++; if (if_s.out_valid !== 1'b0 || if_s.busy !== 1'b0) begin errors++; $display("[TB] FAIL hold_single_xfer got vld=%b busy=%b want 0/0", if_s.out_valid, if_s.busy); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] xb, yb;
    logic [3:0] mb;
    logic [16:0] es;
    int lat;
    set_rows_random();
    xb = 8'($urandom_range(1, 255));
    yb = 8'($urandom_range(1, 255));
    mb = 4'($urandom);
    es = model(xb, yb, mb, 1'b1);
    @(negedge clk);
    if_s.in_valid = 1'b1; if_s.in_x = 8'd17; if_s.in_y = 8'd23; if_s.cfg_row_mask = 4'hF;
    @(posedge clk);
    #1;
    if_s.in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (if_s.out_valid) lat = n + 1;
    end
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL b2b_first_latency got %0d want 5", lat); end
    @(negedge clk);
    if_s.out_ready = 1'b1;
    if_s.in_valid = 1'b1; if_s.in_x = xb; if_s.in_y = yb; if_s.cfg_row_mask = mb;
    @(posedge clk);
    #1;
    if_s.out_ready = 1'b0;
    checks++; if (if_s.busy !== 1'b0 || if_s.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_handoff got busy=%b rdy=%b want 0/1", if_s.busy, if_s.in_ready); end
    @(posedge clk);
    #1;
    if_s.in_valid = 1'b0;
    checks++; if (if_s.busy !== 1'b1 || if_s.mul_x !== xb) begin errors++; $display("[TB] FAIL b2b_accept got busy=%b mul_x=%h want 1/%h", if_s.busy, if_s.mul_x, xb); end
    lat = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      @(posedge clk);
      #1;
      if (if_s.out_valid) lat = n + 1;
    end
    checks++; if (lat !== 5) begin errors++; $display("[TB] FAIL b2b_second_latency got %0d want 5", lat); end
    checks++; if ({if_s.out_sat, if_s.out_p} !== es) begin errors++; $display("[TB] FAIL b2b_second_p got %b/%h want %b/%h", if_s.out_sat, if_s.out_p, es[16], es[15:0]); end
    @(negedge clk);
    if_s.out_ready = 1'b1;
    @(posedge clk);
    #1;
    if_s.out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int lat;
    logic [15:0] ps, pw;
    logic ss, sw;
    logic [7:0] mx, x, y;
    logic [16:0] es;
    bit stray;
    set_rows_random();
    @(negedge clk);
    if_s.in_valid = 1'b1; if_s.in_x = 8'd99; if_s.in_y = 8'd45; if_s.cfg_row_mask = 4'hF;
    @(posedge clk);
    #1;
    if_s.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (if_s.out_valid !== 1'b0 || if_s.busy !== 1'b0 || if_s.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL abort_state got vld=%b busy=%b rdy=%b want 0/0/1", if_s.out_valid, if_s.busy, if_s.in_ready); end
    checks++; if (if_s.out_p !== 16'h0 || if_s.out_sat !== 1'b0 || if_s.mul_x !== 8'h0 || if_s.mul_y !== 8'h0) begin errors++; $display("[TB] FAIL abort_outputs got %h/%b/%h/%h want 0000/0/00/00", if_s.out_p, if_s.out_sat, if_s.mul_x, if_s.mul_y); end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (if_s.out_valid) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_pulse got out_valid=1 want 0"); end
    x = 8'($urandom_range(1, 255));
    y = 8'($urandom_range(1, 255));
    es = model(x, y, 4'b1011, 1'b1);
    applyStimulus(x, y, 4'b1011, lat, ps, ss, pw, sw, mx);
    checks++; if (lat !== 5 || {ss, ps} !== es) begin errors++; $display("[TB] FAIL abort_recover got lat=%0d %b/%h want 5 %b/%h", lat, ss, ps, es[16], es[15:0]); end
  endtask

  initial begin
    if_s.in_valid = 1'b0;
    if_s.in_x = 8'd0;
    if_s.in_y = 8'd0;
    if_s.cfg_row_mask = 4'd0;
    if_s.out_ready = 1'b0;
    set_rows(9'd0, 7'd0);
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_back_to_back();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
